// File: rtl/keypad_press_injector.sv
// -----------------------------------------------------------------------------
// keypad_press_injector
//
// Keypad-side responder for a 4x4 hex keypad row/column scanner. Key codes
// arrive on a valid/ready stream, wait in a small FIFO, and are played out one
// at a time as a timed press: while a key is held, its row line follows the
// scanner's strobe on the key's column. During each press the scanner's
// Code/Valid result is checked against the key being pressed.
//
// Handshake: a transfer happens on a rising clock edge where in_valid and
// in_ready are both 1. in_ready depends only on the registered FIFO count, so
// a pop in the same cycle never opens room for a push while the FIFO is full.
//
// Ports
//   clock         in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high reset
//   in_code       in   4  key to press (0..F)
//   in_valid      in   1  in_code is valid
//   in_ready      out  1  FIFO can accept a code
//   Col           in   4  column strobe from the scanner
//   Row           out  4  row return to the scanner
//   scan_code     in   4  scanner Code output
//   scan_valid    in   1  scanner Valid output
//   key_active    out  1  a key is currently held
//   cur_code      out  4  key being held (last key held when idle)
//   presses_done  out  8  completed presses, wraps 255 -> 0
//   err_mismatch  out  1  sticky: scanner reported a different code in a press
//   err_missed    out  1  sticky: a press ended without a matching scan_valid
//   fsm_state     out  2  current FSM state (0 IDLE, 1 PRESS, 2 GAP)
// -----------------------------------------------------------------------------
module keypad_press_injector #(
    parameter int HOLD_CYCLES = 60,
    parameter int GAP_CYCLES  = 20,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    input  logic [3:0] scan_code,
    input  logic       scan_valid,
    output logic       key_active,
    output logic [3:0] cur_code,
    output logic [7:0] presses_done,
    output logic       err_mismatch,
    output logic       err_missed,
    output logic [1:0] fsm_state
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int MAXT  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(MAXT + 1);

    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          pop;
    logic          press_end;

    // ---------------------------------------------------------------- FIFO
    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          fifo_empty;

    assign in_ready   = (count < DEPTH);
    assign push       = in_valid & in_ready;
    assign fifo_empty = (count == '0);

    // Storage needs no reset; only pointers and count define occupancy.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_code;
        end
    end

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // The timer is loaded with N-1 and the state ends when it reads 0, giving
    // exactly N cycles in PRESS and GAP; IDLE adds one cycle for the pop.
    always_comb begin
        state_next = state;
        timer_next = timer;
        pop        = 1'b0;
        press_end  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    timer_next = HOLD_LOAD;
                    state_next = PRESS;
                end
            end
            PRESS: begin
                if (timer == '0) begin
                    press_end  = 1'b1;
                    timer_next = GAP_LOAD;
                    state_next = GAP;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            GAP: begin
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign key_active = (state == PRESS);
    assign fsm_state  = state;

    // ---------------------------------------------------------- Checking
    logic seen;
    logic scan_match;
    logic scan_wrong;

    assign scan_match = key_active & scan_valid & (scan_code == cur_code);
    assign scan_wrong = key_active & scan_valid & (scan_code != cur_code);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_code     <= 4'h0;
            seen         <= 1'b0;
            presses_done <= 8'h00;
            err_mismatch <= 1'b0;
            err_missed   <= 1'b0;
        end else begin
            if (pop) begin
                cur_code <= mem[rd_ptr];
                seen     <= 1'b0;
            end else if (scan_match) begin
                seen <= 1'b1;
            end
            if (scan_wrong) begin
                err_mismatch <= 1'b1;
            end
            // A match on the final held cycle still counts for this press.
            if (press_end) begin
                presses_done <= presses_done + 8'd1;
                if (!(seen | scan_match)) begin
                    err_missed <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------- Row drive
    // Key k sits at row k[3:2], column k[1:0]; the row simply mirrors the
    // column strobe so the scanner sees no added latency.
    always_comb begin
        Row = 4'b0000;
        if (key_active && Col[cur_code[1:0]]) begin
            Row = 4'b0001 << cur_code[3:2];
        end
    end

endmodule

// File: tb/tb_keypad_press_injector.sv
// -----------------------------------------------------------------------------
// tb_keypad_press_injector
//
// Directed bench for keypad_press_injector with default parameters
// (HOLD_CYCLES=60, GAP_CYCLES=20, FIFO_DEPTH=4). Inputs change and outputs
// are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_press_injector;

    localparam int HOLD    = 60;
    localparam int GAP     = 20;
    localparam int SPACING = HOLD + GAP + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Col;
    logic [3:0] Row;
    logic [3:0] scan_code;
    logic       scan_valid;
    logic       key_active;
    logic [3:0] cur_code;
    logic [7:0] presses_done;
    logic       err_mismatch;
    logic       err_missed;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_press_injector dut (
        .clock        (clock),
        .reset        (reset),
        .in_code      (in_code),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .Col          (Col),
        .Row          (Row),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .key_active   (key_active),
        .cur_code     (cur_code),
        .presses_done (presses_done),
        .err_mismatch (err_mismatch),
        .err_missed   (err_missed),
        .fsm_state    (fsm_state)
    );

    // ------------------------------------------------- clock / reset
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_code    = 4'h0;
        Col        = 4'h0;
        scan_valid = 1'b0;
        scan_code  = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // ------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_active(input string tag);
        int n;
        n = 0;
        while (!key_active && n < 300) begin
            tick();
            n++;
        end
        check(tag, key_active, 1);
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (key_active && n < 300) begin
            tick();
            n++;
        end
        check(tag, key_active, 0);
    endtask

    // ------------------------------------------------- stimulus
    logic [3:0] exp_q[$];
    logic [3:0] cur_exp;
    int hold, row_bad, pushed, rises, falls, cyc, last_rise, press_cyc;
    int rise_cyc, acc_cyc, accepted;
    bit prev_ka, saw_stall;

    initial begin
        // ---------------- reset state
        do_reset();
        check("rst_row", Row, 4'h0);
        check("rst_key_active", key_active, 0);
        check("rst_cur_code", cur_code, 4'h0);
        check("rst_presses", presses_done, 8'd0);
        check("rst_err_mismatch", err_mismatch, 0);
        check("rst_err_missed", err_missed, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", fsm_state, 2'd0);

        // ---------------- 1: single press of 0x5, Col=0010 -> Row=0010
        in_code  = 4'h5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_active("t1_start");
        check("t1_cur_code", cur_code, 4'h5);
        hold    = 0;
        row_bad = 0;
        while (key_active && hold < 200) begin
            Col        = 4'b0010;
            scan_valid = (hold == 20);
            scan_code  = 4'h5;
            #1;
            if (Row !== 4'b0010) row_bad++;
            if (hold == 10) begin
                // Strobe on another column: key 5 must not answer.
                Col = 4'b0001;
                #1;
                check("t1_row_other_col", Row, 4'h0);
                Col = 4'b0010;
                #1;
            end
            hold++;
            tick();
        end
        scan_valid = 1'b0;
        check("t1_hold_cycles", hold, HOLD);
        check("t1_row_bad_cycles", row_bad, 0);
        check("t1_row_released", Row, 4'h0);
        check("t1_presses", presses_done, 8'd1);
        check("t1_err_mismatch", err_mismatch, 0);
        check("t1_err_missed", err_missed, 0);
        check("t1_state_gap", fsm_state, 2'd2);

        // ---------------- 2: 0x0..0xF back-to-back with a scanner-like responder
        do_reset();
        pushed = 0; rises = 0; falls = 0; cyc = 0; last_rise = 0; press_cyc = 0;
        prev_ka = 1'b0; saw_stall = 1'b0; cur_exp = 4'h0;
        while (falls < 16 && cyc < 3000) begin
            if (key_active && !prev_ka) begin
                if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                else cur_exp = 4'hx;
                check("t2_code_order", cur_code, cur_exp);
                if (rises > 0) check("t2_pop_spacing", cyc - last_rise, SPACING);
                last_rise = cyc;
                rises++;
                press_cyc = 0;
            end
            if (!key_active && prev_ka) falls++;
            if (key_active) begin
                Col        = 4'b0001 << cur_exp[1:0];
                scan_valid = (press_cyc == 30);
                scan_code  = cur_exp;
                #1;
                check("t2_row", Row, 4'b0001 << cur_exp[3:2]);
                press_cyc++;
            end else begin
                Col        = 4'h0;
                scan_valid = 1'b0;
            end
            in_valid = (pushed < 16);
            in_code  = pushed[3:0];
            if (in_valid && in_ready) begin
                exp_q.push_back(in_code);
                pushed++;
            end else if (in_valid && !saw_stall) begin
                // Four codes fill the FIFO and one has already been popped
                // into the key, so the first stall comes after five accepts.
                saw_stall = 1'b1;
                check("t2_accepts_before_stall", pushed, 5);
            end
            prev_ka = key_active;
            tick();
            cyc++;
        end
        in_valid   = 1'b0;
        scan_valid = 1'b0;
        Col        = 4'h0;
        check("t2_stall_seen", saw_stall, 1);
        check("t2_all_pushed", pushed, 16);
        check("t2_presses_seen", falls, 16);
        check("t2_queue_drained", exp_q.size(), 0);
        check("t2_presses", presses_done, 8'd16);
        check("t2_err_mismatch", err_mismatch, 0);
        check("t2_err_missed", err_missed, 0);

        // ---------------- 3: wrong scanner code during a press
        do_reset();
        in_code  = 4'hA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_active("t3_start");
        repeat (3) tick();
        scan_valid = 1'b1;
        scan_code  = 4'hB;
        tick();
        scan_valid = 1'b0;
        check("t3_err_mismatch_set", err_mismatch, 1);
        check("t3_err_missed_not_yet", err_missed, 0);
        wait_release("t3_release");
        check("t3_err_mismatch_sticky", err_mismatch, 1);
        check("t3_err_missed_set", err_missed, 1);
        check("t3_presses", presses_done, 8'd1);

        // ---------------- 4: no scanner response -> err_missed at press end
        do_reset();
        in_code  = 4'h3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_active("t4_start");
        hold = 0;
        while (key_active && hold < 200) begin
            if (hold == HOLD - 1) check("t4_missed_last_cycle", err_missed, 0);
            hold++;
            tick();
        end
        check("t4_hold_cycles", hold, HOLD);
        check("t4_err_missed", err_missed, 1);
        check("t4_presses", presses_done, 8'd1);
        check("t4_state_gap", fsm_state, 2'd2);
        // scan_valid during GAP is ignored.
        scan_valid = 1'b1;
        scan_code  = 4'hF;
        tick();
        scan_valid = 1'b0;
        check("t4_gap_scan_ignored", err_mismatch, 0);

        // ---------------- 5: reset in the middle of a press of 0xC
        do_reset();
        in_valid = 1'b1;
        in_code  = 4'hC;
        tick();
        in_code  = 4'h1;
        tick();
        in_code  = 4'h2;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        Col = 4'b0001;
        #1;
        check("t5_row_before_reset", Row, 4'b1000);
        reset = 1'b1;
        #1;
        check("t5_row_async_reset", Row, 4'h0);
        check("t5_key_active_async", key_active, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("t5_in_ready", in_ready, 1);
        check("t5_key_active", key_active, 0);
        check("t5_presses", presses_done, 8'd0);
        repeat (5) tick();
        check("t5_queue_empty", key_active, 0);
        check("t5_state_idle", fsm_state, 2'd0);
        Col = 4'h0;

        // ---------------- 6a: full FIFO with a same-cycle pop accepts nothing
        do_reset();
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_code = k[3:0];
            tick();
        end
        check("t6_full", in_ready, 0);
        in_code  = 4'h6;
        cyc      = 0;
        rise_cyc = -1;
        acc_cyc  = -1;
        prev_ka  = key_active;
        while (acc_cyc < 0 && cyc < 300) begin
            if (key_active && !prev_ka) begin
                rise_cyc = cyc;
                check("t6_second_code", cur_code, 4'h2);
            end
            if (in_ready) acc_cyc = cyc;
            prev_ka = key_active;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("t6_push_after_pop", acc_cyc, rise_cyc);

        // ---------------- 6b: 256 presses wrap presses_done to 0
        do_reset();
        accepted = 0; falls = 0; cyc = 0;
        prev_ka  = 1'b0;
        while (falls < 256 && cyc < 25000) begin
            in_valid = (accepted < 256);
            in_code  = 4'($urandom_range(0, 15));
            if (in_valid && in_ready) accepted++;
            if (!key_active && prev_ka) begin
                falls++;
                if (falls == 255) check("t6_presses_255", presses_done, 8'd255);
                if (falls == 256) check("t6_presses_wrap", presses_done, 8'd0);
            end
            prev_ka = key_active;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("t6_press_count", falls, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
